exc_commit_ctrl: RTL and testbench
==================================

# exc_commit_ctrl

Sequencer that turns the memory-stage exception decision (is_except / except_type / except_pc) into an ordered commit: pipeline squash, a single CP0 exception-field write (or ERET clear), and a held PC redirect handshake to fetch. Sits between the exception decoder and CP0/fetch/hazard logic. Guarantees exactly one CP0 update and one redirect per exception, however long memory stalls or fetch back-pressure last.

## Interface
- EXC_ENTRY, 32'hBFC00380, common exception entry; informational only, because redirect_pc always comes from except_pc.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- is_except  in  1  decoder: exception/ERET present in M.
- except_type  in  32  decoder code: 0x1 Int, 0x4 AdEL, 0x5 AdES, 0x8 Sys, 0x9 Bp, 0xa RI, 0xc Ov, 0xe ERET.
- except_pc  in  32  redirect target from decoder.
- pcM  in  32  PC of the instruction in M.
- is_in_delayslotM  in  1  M instruction is in a branch delay slot.
- bad_addrM  in  32  faulting address, already muxed by the caller (PC for fetch AdEL, data address for load/store).
- stallM  in  1  M stage frozen, e.g. data-memory wait.
- fetch_ready  in  1  fetch accepts the redirect this cycle.
- flush_all  out  1  squash F..W.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  32  redirect target.
- cp0_exc_we  out  1  one-cycle pulse: write EPC, Cause.ExcCode, Cause.BD; set Status.EXL.
- cp0_epc  out  32  EPC value.
- cp0_exccode  out  5  Cause.ExcCode.
- cp0_bd  out  1  Cause.BD.
- cp0_badv_we  out  1  one-cycle pulse: write BadVAddr.
- cp0_badvaddr  out  32  BadVAddr value.
- cp0_eret  out  1  one-cycle pulse: clear Status.EXL.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, COMMIT, REDIRECT.
- IDLE:
  - Accept when is_except=1 and stallM=0. Capture into holding registers: except_type, except_pc, pcM, is_in_delayslotM, bad_addrM. Go to COMMIT.
  - is_except while stallM=1: no capture, stay IDLE; the decoder re-evaluates each cycle.
- COMMIT (exactly 1 cycle):
  - Captured type 0xe: cp0_eret=1, no CP0 field writes.
  - Otherwise: cp0_exc_we=1; cp0_badv_we=1 only for types 0x4 and 0x5.
  - Always go to REDIRECT.
- REDIRECT: redirect_valid=1 and redirect_pc = captured except_pc, both held until fetch_ready=1; then return to IDLE.
- While busy, is_except, stallM and all other capture inputs are ignored.
- CP0 field mapping:
  - ExcCode: 0x1→0, 0x4→4, 0x5→5, 0x8→8, 0x9→9, 0xa→10, 0xc→12.
  - Any other non-0xe code → ExcCode 10 (RI).
  - cp0_epc = bd ? pcM−4 : pcM, mod 2^32; pcM=0 with bd=1 gives 0xFFFFFFFC.
  - cp0_bd = captured bd; cp0_badvaddr = captured bad_addrM.
- flush_all:
  - Combinational 1 in the accept cycle, so the excepting instruction's M/W side effects are squashed.
  - Registered 1 throughout COMMIT and REDIRECT, including the fetch_ready cycle.
- CP0 data outputs are driven from the holding registers, valid whenever the matching write pulse is high, and hold their value otherwise.

## Timing
- Reset (asynchronous): state=IDLE, holding registers=0, every output 0 (redirect_pc=0, cp0_epc=0, busy=0).
- Reset mid-sequence aborts immediately; no pulse or redirect completes. Release resumes in IDLE.
- Accept in cycle N: flush_all=1 in N; COMMIT in N+1 (pulses high); REDIRECT from N+2.
- redirect_valid rises in N+2. If fetch_ready=1 in N+2, IDLE in N+3; each fetch_ready=0 cycle adds one cycle.
- Minimum spacing between accepts: 3 cycles. A new is_except can be accepted in the first IDLE cycle.
- Each pulse is high for exactly one cycle per accepted event.

## Test plan
- Sys at pcM=0x80001000, bd=0, stallM=0, fetch_ready=1 → flush N..N+2; N+1: cp0_exc_we=1, exccode=8, epc=0x80001000, badv_we=0; N+2: redirect 0xBFC00380; IDLE at N+3.
- AdEL, bd=1, pcM=0x80002004, bad_addrM=0x80003001 → N+1: epc=0x80002000, bd=1, exccode=4, badv_we=1, badvaddr=0x80003001.
- is_except with stallM=1 for 5 cycles, then 0 → no capture during stall; accept on first unstalled cycle; exactly one cp0_exc_we.
- ERET with except_pc=0x80004000 and fetch_ready low 3 cycles → cp0_eret single pulse, cp0_exc_we=0; redirect_valid and redirect_pc=0x80004000 held 4 cycles; flush held until acceptance.
- is_except held high throughout busy → no re-capture, single write pulse; back-to-back Ov then Int accepted 3 cycles apart, exccode 12 then 0.
- rst asserted in COMMIT → all outputs 0 asynchronously; after release, no stale redirect or pulse.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// Exception commit sequencer: squashes the pipeline, issues one CP0 update (or ERET clear),
// then holds a PC redirect toward fetch until it is accepted.
module exc_commit_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_except,
  input  logic [31:0] except_type,
  input  logic [31:0] except_pc,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslotM,
  input  logic [31:0] bad_addrM,
  input  logic        stallM,
  input  logic        fetch_ready,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [31:0] cp0_epc,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_badv_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_eret,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCommit, StRedirect} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_accept;
  logic [4:0]  w_exccode;
  logic        r_is_eret;
  logic        r_has_badv;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_epc;
  logic [4:0]  r_exccode;
  logic        r_bd;
  logic [31:0] r_badvaddr;

  // Gated by rst so every output reads 0 while reset is held.
  assign w_accept = !rst && (r_state == StIdle) && is_except && !stallM;

  always_comb begin
    case (except_type)
      32'h1:   w_exccode = 5'd0;
      32'h4:   w_exccode = 5'd4;
      32'h5:   w_exccode = 5'd5;
      32'h8:   w_exccode = 5'd8;
      32'h9:   w_exccode = 5'd9;
      32'ha:   w_exccode = 5'd10;
      32'hc:   w_exccode = 5'd12;
      default: w_exccode = 5'd10;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_accept) w_state_next = StCommit;
      StCommit:   w_state_next = StRedirect;
      StRedirect: if (fetch_ready) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Decode at capture so CP0 data outputs come straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_eret     <= 1'b0;
      r_has_badv    <= 1'b0;
      r_redirect_pc <= 32'h0;
      r_epc         <= 32'h0;
      r_exccode     <= 5'h0;
      r_bd          <= 1'b0;
      r_badvaddr    <= 32'h0;
    end else if (w_accept) begin
      r_is_eret     <= (except_type == 32'he);
      r_has_badv    <= (except_type == 32'h4) || (except_type == 32'h5);
      r_redirect_pc <= except_pc;
      r_epc         <= is_in_delayslotM ? (pcM - 32'd4) : pcM;
      r_exccode     <= w_exccode;
      r_bd          <= is_in_delayslotM;
      r_badvaddr    <= bad_addrM;
    end
  end

  always_comb begin
    flush_all      = w_accept;
    redirect_valid = 1'b0;
    cp0_exc_we     = 1'b0;
    cp0_badv_we    = 1'b0;
    cp0_eret       = 1'b0;
    busy           = 1'b0;
    unique case (r_state)
      StIdle: begin
      end
      StCommit: begin
        flush_all   = 1'b1;
        busy        = 1'b1;
        cp0_eret    = r_is_eret;
        cp0_exc_we  = !r_is_eret;
        cp0_badv_we = r_has_badv;
      end
      StRedirect: begin
        flush_all      = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign redirect_pc  = r_redirect_pc;
  assign cp0_epc      = r_epc;
  assign cp0_exccode  = r_exccode;
  assign cp0_bd       = r_bd;
  assign cp0_badvaddr = r_badvaddr;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: a timeline model predicts per-cycle control outputs and
// per-exception CP0/redirect contents; a monitor compares them against the DUT.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_except = 1'b0;
  logic [31:0] except_type = 32'h0;
  logic [31:0] except_pc = 32'h0;
  logic [31:0] pcM = 32'h0;
  logic        is_in_delayslotM = 1'b0;
  logic [31:0] bad_addrM = 32'h0;
  logic        stallM = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        flush_all, redirect_valid, cp0_exc_we, cp0_bd, cp0_badv_we, cp0_eret, busy;
  logic [31:0] redirect_pc, cp0_epc, cp0_badvaddr;
  logic [4:0]  cp0_exccode;

  exc_commit_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .is_except        (is_except),
    .except_type      (except_type),
    .except_pc        (except_pc),
    .pcM              (pcM),
    .is_in_delayslotM (is_in_delayslotM),
    .bad_addrM        (bad_addrM),
    .stallM           (stallM),
    .fetch_ready      (fetch_ready),
    .flush_all        (flush_all),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .cp0_exc_we       (cp0_exc_we),
    .cp0_epc          (cp0_epc),
    .cp0_exccode      (cp0_exccode),
    .cp0_bd           (cp0_bd),
    .cp0_badv_we      (cp0_badv_we),
    .cp0_badvaddr     (cp0_badvaddr),
    .cp0_eret         (cp0_eret),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic flush; logic busy; logic rv; logic we; logic eret; logic badv;
  } ctrl_t;
  typedef struct {
    logic eret; logic badv; logic [4:0] code; logic [31:0] epc; logic bd; logic [31:0] bad;
  } txn_t;

  ctrl_t       ctrl_q[$];
  txn_t        txn_q[$];
  logic [31:0] rd_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  // Model state: an exception is outstanding from its accept cycle until its redirect handshake.
  logic pending = 1'b0;
  int   acc_cyc = 0;
  txn_t acc_txn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_code(input logic [31:0] ty);
    case (ty)
      32'h1:   return 5'd0;
      32'h4:   return 5'd4;
      32'h5:   return 5'd5;
      32'h8:   return 5'd8;
      32'h9:   return 5'd9;
      32'ha:   return 5'd10;
      32'hc:   return 5'd12;
      default: return 5'd10;
    endcase
  endfunction

  task automatic drive_cycle(input logic ie, input logic [31:0] ty, input logic [31:0] tgt,
                             input logic [31:0] pc, input logic bd, input logic [31:0] bad,
                             input logic st, input logic fr);
    ctrl_t e;
    logic  accept;
    @(posedge clk);
    #1;
    is_except = ie; except_type = ty; except_pc = tgt; pcM = pc;
    is_in_delayslotM = bd; bad_addrM = bad; stallM = st; fetch_ready = fr;
    cyc++;
    e = '{default: 1'b0};
    e.busy = pending;
    e.rv   = pending && (cyc >= acc_cyc + 2);
    if (pending && cyc == acc_cyc + 1) begin
      e.eret = acc_txn.eret;
      e.we   = !acc_txn.eret;
      e.badv = acc_txn.badv;
    end
    accept  = !pending && ie && !st;
    e.flush = pending || accept;
    if (e.rv && fr) pending = 1'b0;
    if (accept) begin
      pending      = 1'b1;
      acc_cyc      = cyc;
      acc_txn.eret = (ty == 32'he);
      acc_txn.badv = (ty == 32'h4) || (ty == 32'h5);
      acc_txn.code = ref_code(ty);
      acc_txn.epc  = bd ? pc - 32'd4 : pc;
      acc_txn.bd   = bd;
      acc_txn.bad  = bad;
      txn_q.push_back(acc_txn);
      rd_q.push_back(tgt);
    end
    ctrl_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"}, {31'h0, flush_all}, 32'h0);
    chk({tag, "_rv"}, {31'h0, redirect_valid}, 32'h0);
    chk({tag, "_rpc"}, redirect_pc, 32'h0);
    chk({tag, "_we"}, {31'h0, cp0_exc_we}, 32'h0);
    chk({tag, "_epc"}, cp0_epc, 32'h0);
    chk({tag, "_code"}, {27'h0, cp0_exccode}, 32'h0);
    chk({tag, "_bd"}, {31'h0, cp0_bd}, 32'h0);
    chk({tag, "_badv_we"}, {31'h0, cp0_badv_we}, 32'h0);
    chk({tag, "_badv"}, cp0_badvaddr, 32'h0);
    chk({tag, "_eret"}, {31'h0, cp0_eret}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    is_except = 1'b1; stallM = 1'b0; fetch_ready = 1'b1;
    #1 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    ctrl_q.delete(); txn_q.delete(); rd_q.delete();
    pending = 1'b0;
    is_except = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ctrl_q.size() == 0) begin
        chk("ctrl_q_underflow", 32'h1, 32'h0);
      end else begin
        ctrl_t e;
        e = ctrl_q.pop_front();
        chk("flush_all", {31'h0, flush_all}, {31'h0, e.flush});
        chk("busy", {31'h0, busy}, {31'h0, e.busy});
        chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, e.rv});
        chk("cp0_exc_we", {31'h0, cp0_exc_we}, {31'h0, e.we});
        chk("cp0_eret", {31'h0, cp0_eret}, {31'h0, e.eret});
        chk("cp0_badv_we", {31'h0, cp0_badv_we}, {31'h0, e.badv});
      end
      if (cp0_exc_we || cp0_eret) begin
        if (txn_q.size() == 0) begin
          chk("unexpected_pulse", 32'h1, 32'h0);
        end else begin
          txn_t t;
          t = txn_q.pop_front();
          chk("pulse_kind_eret", {31'h0, cp0_eret}, {31'h0, t.eret});
          if (!t.eret) begin
            chk("cp0_exccode", {27'h0, cp0_exccode}, {27'h0, t.code});
            chk("cp0_epc", cp0_epc, t.epc);
            chk("cp0_bd", {31'h0, cp0_bd}, {31'h0, t.bd});
          end
          if (t.badv) chk("cp0_badvaddr", cp0_badvaddr, t.bad);
        end
      end
      if (redirect_valid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_redirect", 32'h1, 32'h0);
        end else begin
          chk("redirect_pc", redirect_pc, rd_q[0]);
          if (fetch_ready) void'(rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] tys [10];
    tys = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h1f};

    #3 check_all_zero("reset");
    #4 rst = 1'b0;

    idle(2);
    // Sys, no delay slot
    drive_cycle(1'b1, 32'h8, 32'hBFC00380, 32'h80001000, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);
    // AdEL in delay slot
    drive_cycle(1'b1, 32'h4, 32'hBFC00380, 32'h80002004, 1'b1, 32'h80003001, 1'b0, 1'b1);
    idle(3);
    // Stalled exception must not be captured until stallM drops
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 32'hc, 32'hBFC00380, 32'h80005000, 1'b0, 32'h0, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'hc, 32'hBFC00380, 32'h80005000, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);
    // ERET with fetch back-pressure
    drive_cycle(1'b1, 32'he, 32'h80004000, 32'h80006000, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(2);
    // is_except held through busy: Ov then Int back-to-back
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 32'hc, 32'hBFC00380, 32'h80007000, 1'b0, 32'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h1, 32'hBFC00380, 32'h80007100, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);
    // EPC wrap and unknown code
    drive_cycle(1'b1, 32'h3, 32'hBFC00380, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    idle(3);
    // Reset while in COMMIT
    drive_cycle(1'b1, 32'h5, 32'hBFC00380, 32'h80008000, 1'b0, 32'h80009002, 1'b0, 1'b1);
    reset_mid();
    idle(4);

    for (int i = 0; i < 800; i++) begin
      drive_cycle(($urandom % 3) != 0, tys[$urandom % 10], $urandom, {$urandom} & 32'hFFFF_FFFC,
                  $urandom % 2, $urandom, ($urandom % 4) == 0, ($urandom % 3) != 0);
    end
    idle(6);
    chk("txn_q_drained", txn_q.size(), 32'h0);
    chk("rd_q_drained", rd_q.size(), 32'h0);

    @(posedge clk);
    #1 mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
